// File: rtl/irq_ctl.sv
// Interrupt sequencer for pc_gen: post-reset PC_RST window, fixed-priority capture,
// PC_KEP flush, single-cycle PC_IRQ redirect with vector/ack, then in-service until return.
module irq_ctl #(
    parameter int          NSRC      = 4,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0050,
    parameter int          VEC_SHIFT = 4,
    parameter int          FLUSH_CYC = 2,
    parameter int          RST_CYC   = 2
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic            irq_en,
    input  logic            hold_i,
    input  logic [31:0]     pc_i,
    input  logic            ret_i,
    output logic [3:0]      pc_prectl,
    output logic [31:0]     irq_vec,
    output logic [31:0]     zz_spc,
    output logic [NSRC-1:0] irq_ack,
    output logic            in_isr
);

    localparam logic [3:0] PC_IGN = 4'b0001;
    localparam logic [3:0] PC_KEP = 4'b0010;
    localparam logic [3:0] PC_IRQ = 4'b0100;
    localparam logic [3:0] PC_RST = 4'b1000;
    localparam int         IW     = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_VECTOR = 3'd3,
        ST_ISR    = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [IW-1:0]   idx_r;
    logic [NSRC-1:0] pend_r;
    logic [31:0]     irq_vec_r, zz_spc_r;
    logic [NSRC-1:0] irq_ack_r;
    logic            capture_s;

    // Index 0 has the highest priority, so the scan ends on the lowest set bit.
    function automatic logic [IW-1:0] lowest_set(input logic [NSRC-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IW'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [NSRC-1:0] one_hot(input logic [IW-1:0] i);
        logic [NSRC-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Next-state logic; FLUSH deliberately ignores hold/enable/source changes.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_RST: begin
                if (cnt_r == 4'(RST_CYC - 1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_IDLE: begin
                if (irq_en && (|pend_r) && !hold_i) begin
                    state_s   = ST_FLUSH;
                    cnt_s     = 4'd0;
                    capture_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == 4'(FLUSH_CYC - 1)) begin
                    state_s = ST_VECTOR;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_VECTOR: state_s = ST_ISR;
            ST_ISR: begin
                if (ret_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISR;
                end
            end
            default: begin
                state_s = ST_RST;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, sample and captured-context registers; vector/ack load on entry to VECTOR.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RST;
            cnt_r     <= 4'd0;
            pend_r    <= '0;
            idx_r     <= '0;
            zz_spc_r  <= 32'd0;
            irq_vec_r <= VEC_BASE;
            irq_ack_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pend_r  <= irq_src;
            if (capture_s) begin
                idx_r    <= lowest_set(pend_r);
                zz_spc_r <= pc_i;
            end
            if (state_s == ST_VECTOR) begin
                irq_vec_r <= VEC_BASE + ({{(32 - IW){1'b0}}, idx_r} << VEC_SHIFT);
                irq_ack_r <= one_hot(idx_r);
            end else begin
                irq_ack_r <= '0;
            end
        end
    end

    // Control outputs decoded from the registered state only.
    always_comb begin
        pc_prectl = PC_IGN;
        in_isr    = 1'b0;
        case (state_r)
            ST_RST:    pc_prectl = PC_RST;
            ST_IDLE:   pc_prectl = PC_IGN;
            ST_FLUSH:  pc_prectl = PC_KEP;
            ST_VECTOR: pc_prectl = PC_IRQ;
            ST_ISR: begin
                pc_prectl = PC_IGN;
                in_isr    = 1'b1;
            end
            default:   pc_prectl = PC_RST;
        endcase
    end

    assign irq_vec = irq_vec_r;
    assign zz_spc  = zz_spc_r;
    assign irq_ack = irq_ack_r;

endmodule
